booth_product_accumulator: RTL and testbench
============================================

Name: booth_product_accumulator

Overview:
- Downstream consumer of the sequential Booth multiplier's signed 64-bit product.
- Accepts one product per valid/ready handshake and sums a burst of `len` products into a wider signed accumulator, saturating on overflow.
- Presents the final sum on a valid/ready output port.
- Forms the accumulate half of the dot-product / MAC path.

Parameters:
- PROD_W, 64, product width; two's-complement signed.
- ACC_W, 72, accumulator and output width; signed. Must be ≥ PROD_W.
- CNT_W, 8, width of the burst-length input and of the internal counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  synchronous abort; discards any partial or held burst.
- len  input  CNT_W  products per burst; sampled on the first accepted product of a burst; 0 is treated as 1.
- prod_valid  input  1  product is valid.
- prod_ready  output  1  block can accept a product.
- product  input  PROD_W  signed product from the multiplier.
- acc_valid  output  1  acc_out holds a completed burst sum.
- acc_ready  input  1  consumer accepts acc_out.
- acc_out  output  ACC_W  signed saturated burst sum.
- overflow  output  1  saturation occurred in the burst now on acc_out.

Behaviour:
- Reset: reset low at a rising edge gives:
  - state=IDLE, accumulator=0, count=0, len_q=0
  - acc_out=0, acc_valid=0, overflow=0, prod_ready=0
- prod_ready is 1 from the first cycle after reset is released while in IDLE or ACCUM.
- Priority per edge: reset > flush > handshakes.
- States:
  - IDLE: accumulator=0, prod_ready=1. On accept:
    - len_q = max(len,1)
    - sum = product sign-extended
    - count = 1
    - go to HOLD if len_q==1, else ACCUM.
  - ACCUM: prod_ready=1. On accept:
    - sum += product
    - count++
    - when count reaches len_q on this accept, go to HOLD.
    - len changes are ignored until the next burst.
  - HOLD: prod_ready=0 and acc_valid=1.
    - acc_out and overflow are stable until acc_valid && acc_ready.
    - That handshake returns to IDLE and clears the accumulator, count and overflow. acc_out keeps its last value but is ignored.
- Latency: acc_valid rises on the edge following the cycle of the last accepted product.
  - prod_ready is low in that same cycle (registered).
  - Minimum burst turnaround is len+1 cycles when acc_ready is held high.
- Arithmetic:
  - Each add is computed at ACC_W+1 bits.
  - Result > 2^(ACC_W-1)-1 clamps to max positive; result < -2^(ACC_W-1) clamps to min negative.
  - Any clamp sets the sticky overflow flag for the burst.
  - Once saturated, later additions continue from the clamped value. There is no wrap.
- Products arriving while prod_ready=0 (HOLD, or reset) are not consumed. The upstream must hold product and prod_valid until ready.
- A product offered in the same cycle as the acc handshake is not accepted (prod_ready=0 in HOLD). It is accepted one cycle later in IDLE.
- flush: next state IDLE, accumulator=0, count=0, acc_valid=0, overflow=0. Any product offered in the same cycle is dropped.
- reset mid-burst behaves identically to power-up reset. No partial result is emitted.
- count never exceeds len_q; no wrap. len=2^CNT_W-1 is supported.
- With defaults, 255 products of PROD_W bits cannot overflow 72 bits. Saturation is reachable only when ACC_W < PROD_W+CNT_W.

Test Plan:
- Reset then len=4; products -2000, 6300, 5200, -3250 back-to-back; acc_ready=1. Expect:
  - acc_valid high for 1 cycle, one cycle after the 4th accept
  - acc_out=6250, overflow=0
  - prod_ready low exactly that cycle
- len=0, product=98765 → burst of 1: acc_out=98765. len=2, products -500×2000 and -999×999 (-1000000, -998001) → acc_out=-1998001.
- Backpressure: len=2, products 90, 70, acc_ready=0 for 5 cycles. Expect:
  - acc_out=160 stable and acc_valid held for the whole stall
  - prod_ready=0 during the stall
  - a third product is held off until the cycle after acc_ready=1
- Saturation, instance PROD_W=32, ACC_W=34, len=5:
  - five products of 0x7FFF_FFFF → acc_out=0x1_FFFF_FFFF, overflow=1
  - five products of 0x8000_0000 → acc_out=0x2_0000_0000, overflow=1
  - the next burst of 1 with product 1 → overflow=0
- Abort: len=4, accept 2 products (50, -40). Then:
  - flush=1 → IDLE, no acc_valid
  - a new len=1 burst of 7 yields acc_out=7
  - repeat with reset=0 instead of flush → same result, all outputs 0 during reset
- Simultaneous events: in HOLD assert acc_ready and prod_valid(product=5) in the same cycle. Expect:
  - product not consumed that cycle
  - product accepted the next cycle
  - a len=1 burst yields acc_out=5

Source files
------------

// File: rtl/booth_product_accumulator.sv
// Burst accumulator for signed Booth products: sums len products into a wider
// saturating accumulator and presents the sum on a valid/ready output port.
module booth_product_accumulator #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 72,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [CNT_W-1:0]  len,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] product,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic [1:0]        o_dbg_state
);

   // Both ports: a transfer happens on a rising edge where valid && ready,
   // ready never depends on valid, and a producer holds its data until taken.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_HOLD = 2'd2} state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_run;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_len_q;
   logic               r_ovf;
   logic [ACC_W-1:0]   r_acc_out;
   logic               r_ovf_out;

   logic               w_accept;
   logic               w_out_hs;
   logic [CNT_W-1:0]   w_len_eff;
   logic               w_last;
   logic [ACC_W:0]     w_sum;
   logic               w_clamp;
   logic [ACC_W-1:0]   w_res;

   assign w_accept  = prod_valid && prod_ready && !flush;
   assign w_out_hs  = acc_valid && acc_ready && !flush;
   assign w_len_eff = (len == '0) ? CNT_W'(1) : len;
   assign w_last    = (r_state == S_IDLE) ? (w_len_eff == CNT_W'(1))
                                          : ((r_cnt + CNT_W'(1)) == r_len_q);

   // One guard bit: the add cannot wrap, so disagreeing top bits mean clamp.
   assign w_sum   = {r_acc[ACC_W-1], r_acc}
                  + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
   assign w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];
   assign w_res   = !w_clamp     ? w_sum[ACC_W-1:0] :
                    w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_last ? S_HOLD : S_ACCUM;
         S_ACCUM: if (w_accept && w_last) w_next = S_HOLD;
         S_HOLD:  if (w_out_hs) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_comb begin
      prod_ready  = r_run && (r_state != S_HOLD);
      acc_valid   = (r_state == S_HOLD);
      acc_out     = r_acc_out;
      overflow    = r_ovf_out;
      o_dbg_state = r_state;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_len_q   <= '0;
         r_ovf     <= 1'b0;
         r_acc_out <= '0;
         r_ovf_out <= 1'b0;
      end else if (flush) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_ovf_out <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_res;
         r_cnt <= r_cnt + CNT_W'(1);
         r_ovf <= r_ovf | w_clamp;
         if (r_state == S_IDLE) r_len_q <= w_len_eff;
         if (w_last) begin
            r_acc_out <= w_res;
            r_ovf_out <= r_ovf | w_clamp;
         end
      end else if (w_out_hs) begin
         // acc_out deliberately keeps its last value; only valid qualifies it.
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_ovf_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: a default instance and a narrow
// 32/34-bit instance run in lock-step against a saturating reference sum.
module tb_booth_product_accumulator;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               flush = 1'b0;
   logic [7:0]         len = '0;
   logic               prod_valid = 1'b0;
   logic               acc_ready = 1'b0;
   logic [63:0]        prod_a = '0;
   logic [31:0]        prod_b = '0;
   logic               rdy_a, rdy_b, av_a, av_b, ov_a, ov_b;
   logic [71:0]        out_a;
   logic [33:0]        out_b;
   logic [1:0]         st_a, st_b;

   int n_pass  = 0;
   int n_total = 0;

   logic signed [63:0] pa_q[$];
   logic signed [31:0] pb_q[$];

   always #5 clk = ~clk;

   booth_product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .flush(flush), .len(len),
      .prod_valid(prod_valid), .prod_ready(rdy_a), .product(prod_a),
      .acc_valid(av_a), .acc_ready(acc_ready), .acc_out(out_a),
      .overflow(ov_a), .o_dbg_state(st_a));

   booth_product_accumulator #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .len(len),
      .prod_valid(prod_valid), .prod_ready(rdy_b), .product(prod_b),
      .acc_valid(av_b), .acc_ready(acc_ready), .acc_out(out_b),
      .overflow(ov_b), .o_dbg_state(st_b));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain integer sum of the queued products, clamped after each add.
   function automatic logic [127:0] model(input int aw, input bit use_b, output bit ovf);
      logic signed [127:0] acc, v, hi, lo;
      int n;
      hi  = (128'sd1 <<< (aw - 1)) - 128'sd1;
      lo  = -(128'sd1 <<< (aw - 1));
      acc = '0;
      ovf = 1'b0;
      n   = use_b ? pb_q.size() : pa_q.size();
      for (int i = 0; i < n; i++) begin
         if (use_b) v = pb_q[i];
         else       v = pa_q[i];
         acc = acc + v;
         if (acc > hi)      begin acc = hi; ovf = 1'b1; end
         else if (acc < lo) begin acc = lo; ovf = 1'b1; end
      end
      return acc & ((128'd1 << aw) - 128'd1);
   endfunction

   task automatic push(input logic signed [63:0] a, input logic signed [31:0] b);
      pa_q.push_back(a);
      pb_q.push_back(b);
   endtask

   task automatic offer(input logic [63:0] a, input logic [31:0] b);
      int t;
      prod_a     = a;
      prod_b     = b;
      prod_valid = 1'b1;
      t = 0;
      while (!rdy_a && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("prod_ready_wait", rdy_a, 1);
      @(posedge clk); #1;
      prod_valid = 1'b0;
   endtask

   task automatic check_hold(input string tag);
      logic [127:0] ea, eb;
      bit oa, ob;
      ea = model(72, 1'b0, oa);
      eb = model(34, 1'b1, ob);
      chk({tag, "_valid_a"}, av_a, 1);
      chk({tag, "_valid_b"}, av_b, 1);
      chk({tag, "_ready_low"}, rdy_a, 0);
      chk({tag, "_out_a"}, out_a, ea);
      chk({tag, "_ovf_a"}, ov_a, oa);
      chk({tag, "_out_b"}, out_b, eb);
      chk({tag, "_ovf_b"}, ov_b, ob);
   endtask

   task automatic handshake(input string tag);
      acc_ready = 1'b1;
      @(posedge clk); #1;
      acc_ready = 1'b0;
      chk({tag, "_valid_drop"}, av_a, 0);
      chk({tag, "_ready_back"}, rdy_a, 1);
      pa_q.delete();
      pb_q.delete();
   endtask

   task automatic run_burst(input string tag, input int l, input int stall);
      logic [71:0] held;
      len = 8'(l);
      for (int i = 0; i < pa_q.size(); i++) offer(pa_q[i], pb_q[i]);
      check_hold(tag);
      held = out_a;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk({tag, "_stall_valid"}, av_a, 1);
         chk({tag, "_stall_ready"}, rdy_a, 0);
         chk({tag, "_stall_out"}, out_a, held);
      end
      handshake(tag);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, {av_a, av_b}, 0);
      chk({tag, "_ready"}, {rdy_a, rdy_b}, 0);
      chk({tag, "_out_a"}, out_a, 0);
      chk({tag, "_out_b"}, out_b, 0);
      chk({tag, "_ovf"}, {ov_a, ov_b}, 0);
   endtask

   initial begin
      int l;
      // power-up reset
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", rdy_a, 1);

      push(-2000, -2000); push(6300, 6300); push(5200, 5200); push(-3250, -3250);
      chk("burst4_model", model(72, 1'b0, l[0]), 128'd6250);
      run_burst("burst4", 4, 0);

      push(98765, 98765);
      run_burst("len0", 0, 0);
      push(-1000000, -1000000); push(-998001, -998001);
      run_burst("neg2", 2, 0);

      push(90, 90); push(70, 70);
      run_burst("stall", 2, 5);

      // narrow instance saturates at both rails; wide one never does
      for (int i = 0; i < 5; i++) push(64'sh7FFF_FFFF, 32'sh7FFF_FFFF);
      run_burst("sat_pos", 5, 0);
      for (int i = 0; i < 5; i++) push(-64'sh8000_0000, 32'sh8000_0000);
      run_burst("sat_neg", 5, 0);
      push(1, 1);
      run_burst("sat_clear", 1, 0);

      for (int k = 0; k < 8; k++) begin
         l = $urandom_range(1, 6);
         for (int i = 0; i < l; i++)
            push({$urandom, $urandom}, $urandom);
         run_burst("rand", l, $urandom_range(0, 2));
      end

      for (int i = 0; i < 255; i++) push({$urandom, $urandom}, $urandom);
      run_burst("len255", 255, 0);

      // flush mid-burst, with a product offered in the flush cycle
      len = 8'd4;
      offer(50, 50);
      offer(-40, -40);
      flush = 1'b1; prod_valid = 1'b1; prod_a = 64'd99; prod_b = 32'd99;
      @(posedge clk); #1;
      flush = 1'b0; prod_valid = 1'b0;
      chk("flush_valid", av_a, 0);
      chk("flush_ready", rdy_a, 1);
      chk("flush_state", st_a, 0);
      pa_q.delete(); pb_q.delete();
      push(7, 7);
      run_burst("after_flush", 1, 0);

      // reset mid-burst
      len = 8'd4;
      offer(50, 50);
      offer(-40, -40);
      reset = 1'b0;
      @(posedge clk); #1;
      check_zero("midreset");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      pa_q.delete(); pb_q.delete();
      push(7, 7);
      run_burst("after_reset", 1, 0);

      // acc handshake and product offer in the same cycle
      push(3, 3);
      len = 8'd1;
      offer(3, 3);
      check_hold("simul_first");
      pa_q.delete(); pb_q.delete();
      acc_ready = 1'b1; prod_valid = 1'b1; prod_a = 64'd5; prod_b = 32'd5;
      chk("simul_ready_low", rdy_a, 0);
      @(posedge clk); #1;
      acc_ready = 1'b0;
      chk("simul_not_taken", av_a, 0);
      chk("simul_idle_ready", rdy_a, 1);
      @(posedge clk); #1;
      prod_valid = 1'b0;
      push(5, 5);
      check_hold("simul_second");
      handshake("simul_second");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
